// File: rtl/ensemble_pkg.sv
// ensemble_pkg: shared types and constants for the ensemble voter.
//   voter_state_t   - voter FSM states (COLLECT, VOTE, OUT)
//   VOTE_MAJORITY   - VOTE_MODE value selecting majority voting
//   VOTE_UNANIMOUS  - VOTE_MODE value selecting unanimous voting
//   CNT_WIDTH       - width of the winner vote-count field in the vote beat
package ensemble_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_VOTE    = 2'd1,
        ST_OUT     = 2'd2
    } voter_state_t;

    localparam int unsigned VOTE_MAJORITY  = 0;
    localparam int unsigned VOTE_UNANIMOUS = 1;
    localparam int unsigned CNT_WIDTH      = 8;

endpackage

// File: rtl/axis_broadcast.sv
// axis_broadcast: forks one AXI-Stream input to NUM_CLS outputs.
// Every output channel sees every input beat exactly once and in order; the
// input beat is consumed only after all channels have taken it.
//   clk, rst        - clock, asynchronous active-high reset
//   s_axis_*        - single input stream (tdata/tkeep/tlast/tvalid/tready)
//   m_axis_*        - NUM_CLS output streams, channel i in slice i
module axis_broadcast #(
    parameter int unsigned NUM_CLS    = 3,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned KEEP_WIDTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]         s_axis_tkeep,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    output logic [NUM_CLS*DATA_WIDTH-1:0] m_axis_tdata,
    output logic [NUM_CLS*KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic [NUM_CLS-1:0]            m_axis_tvalid,
    input  logic [NUM_CLS-1:0]            m_axis_tready,
    output logic [NUM_CLS-1:0]            m_axis_tlast
);

    // done[i]: channel i already took the current input beat
    logic [NUM_CLS-1:0] done;
    logic               in_hs;

    assign s_axis_tready = &(done | m_axis_tready);
    assign in_hs         = s_axis_tvalid & s_axis_tready;
    assign m_axis_tvalid = {NUM_CLS{s_axis_tvalid}} & ~done;
    assign m_axis_tdata  = {NUM_CLS{s_axis_tdata}};
    assign m_axis_tkeep  = {NUM_CLS{s_axis_tkeep}};
    assign m_axis_tlast  = {NUM_CLS{s_axis_tlast}};

    // Input handshake retires the beat for all channels; otherwise remember
    // which channels have already accepted it so they are not fed twice.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done <= '0;
        end else if (in_hs) begin
            done <= '0;
        end else begin
            done <= done | (m_axis_tvalid & m_axis_tready);
        end
    end

endmodule

// File: rtl/ensemble_voter.sv
// ensemble_voter: broadcasts feature beats to NUM_CLS classifiers and votes on
// their returned class labels, emitting one vote beat per inference.
//   clk, rst             - clock, asynchronous active-high reset
//   s_axis_*             - feature input stream
//   m_axis_feat_*        - per-classifier feature streams
//   s_axis_res_*         - per-classifier result beats (label in low bits)
//   m_axis_*             - vote stream: {count, label}, one beat, tlast=1
//   disagree_cnt         - saturating count of votes with non-unanimous labels
module ensemble_voter
    import ensemble_pkg::*;
#(
    parameter int unsigned NUM_CLS     = 3,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned KEEP_WIDTH  = 4,
    parameter int unsigned LABEL_WIDTH = 8,
    parameter int unsigned VOTE_MODE   = VOTE_MAJORITY
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]         s_axis_tkeep,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
    input  logic                          s_axis_tlast,
    output logic [NUM_CLS*DATA_WIDTH-1:0] m_axis_feat_tdata,
    output logic [NUM_CLS*KEEP_WIDTH-1:0] m_axis_feat_tkeep,
    output logic [NUM_CLS-1:0]            m_axis_feat_tvalid,
    input  logic [NUM_CLS-1:0]            m_axis_feat_tready,
    output logic [NUM_CLS-1:0]            m_axis_feat_tlast,
    input  logic [NUM_CLS*DATA_WIDTH-1:0] s_axis_res_tdata,
    input  logic [NUM_CLS-1:0]            s_axis_res_tvalid,
    output logic [NUM_CLS-1:0]            s_axis_res_tready,
    output logic [DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]         m_axis_tkeep,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [15:0]                   disagree_cnt
);

    voter_state_t                         state;
    logic [NUM_CLS-1:0]                   captured;
    logic [NUM_CLS-1:0][LABEL_WIDTH-1:0]  labels;
    logic                                 vote_differs;
    logic [NUM_CLS-1:0][CNT_WIDTH-1:0]    match_cnt;
    logic [LABEL_WIDTH-1:0]               best_label;
    logic [CNT_WIDTH-1:0]                 best_cnt;
    logic [LABEL_WIDTH-1:0]               vote_label;
    logic                                 all_equal;
    logic                                 unused_res_bits;

    // Feature fork runs independently of the voter FSM.
    axis_broadcast #(
        .NUM_CLS    (NUM_CLS),
        .DATA_WIDTH (DATA_WIDTH),
        .KEEP_WIDTH (KEEP_WIDTH)
    ) u_broadcast (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tdata  (m_axis_feat_tdata),
        .m_axis_tkeep  (m_axis_feat_tkeep),
        .m_axis_tvalid (m_axis_feat_tvalid),
        .m_axis_tready (m_axis_feat_tready),
        .m_axis_tlast  (m_axis_feat_tlast)
    );

    // Only the label bits of each result slice carry information.
    assign unused_res_bits = ^s_axis_res_tdata;

    assign s_axis_res_tready = (state == ST_COLLECT) ? ~captured : '0;
    assign m_axis_tkeep      = '1;
    assign m_axis_tlast      = 1'b1;

    // Per channel: how many channels (itself included) report the same label.
    always_comb begin
        for (int i = 0; i < NUM_CLS; i++) begin
            match_cnt[i] = '0;
            for (int j = 0; j < NUM_CLS; j++) begin
                if (labels[i] == labels[j]) begin
                    match_cnt[i] = match_cnt[i] + CNT_WIDTH'(1);
                end
            end
        end
    end

    // Strictly-greater scan keeps the lowest channel index on ties.
    always_comb begin
        best_label = labels[0];
        best_cnt   = match_cnt[0];
        for (int i = 1; i < NUM_CLS; i++) begin
            if (match_cnt[i] > best_cnt) begin
                best_label = labels[i];
                best_cnt   = match_cnt[i];
            end
        end
    end

    assign all_equal  = (best_cnt == CNT_WIDTH'(NUM_CLS));
    assign vote_label = ((VOTE_MODE == VOTE_UNANIMOUS) && !all_equal) ? '1 : best_label;

    // Voter FSM: collect one label per channel, vote, hold the vote beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_COLLECT;
            captured      <= '0;
            labels        <= '0;
            vote_differs  <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            disagree_cnt  <= '0;
        end else begin
            case (state)
                ST_COLLECT: begin
                    for (int i = 0; i < NUM_CLS; i++) begin
                        if (s_axis_res_tvalid[i] && !captured[i]) begin
                            labels[i]   <= s_axis_res_tdata[i*DATA_WIDTH +: LABEL_WIDTH];
                            captured[i] <= 1'b1;
                        end
                    end
                    if (&captured) begin
                        state <= ST_VOTE;
                    end
                end
                ST_VOTE: begin
                    m_axis_tdata  <= DATA_WIDTH'({best_cnt, vote_label});
                    vote_differs  <= !all_equal;
                    m_axis_tvalid <= 1'b1;
                    state         <= ST_OUT;
                end
                ST_OUT: begin
                    if (m_axis_tready) begin
                        m_axis_tvalid <= 1'b0;
                        captured      <= '0;
                        if (vote_differs && (disagree_cnt != 16'hFFFF)) begin
                            disagree_cnt <= disagree_cnt + 16'd1;
                        end
                        state <= ST_COLLECT;
                    end
                end
                default: begin
                    state <= ST_COLLECT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ensemble_voter.sv
// tb_ensemble_voter: randomized self-checking bench for ensemble_voter.
// Two instances (majority and unanimous) share stimulus; expected values come
// from a histogram-based vote model and a per-channel delivery scoreboard.
module tb_ensemble_voter;

    localparam int NC = 3;
    localparam int DW = 32;
    localparam int KW = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [DW-1:0]     s_tdata;
    logic [KW-1:0]     s_tkeep;
    logic              s_tvalid;
    logic              s_tready, u_s_tready;
    logic              s_tlast;
    logic [NC*DW-1:0]  feat_tdata, u_feat_tdata;
    logic [NC*KW-1:0]  feat_tkeep, u_feat_tkeep;
    logic [NC-1:0]     feat_tvalid, u_feat_tvalid;
    logic [NC-1:0]     feat_tready;
    logic [NC-1:0]     feat_tlast, u_feat_tlast;
    logic [NC*DW-1:0]  res_tdata;
    logic [NC-1:0]     res_tvalid;
    logic [NC-1:0]     res_tready, u_res_tready;
    logic [DW-1:0]     m_tdata, u_m_tdata;
    logic [KW-1:0]     m_tkeep, u_m_tkeep;
    logic              m_tvalid, u_m_tvalid;
    logic              m_tready;
    logic              m_tlast, u_m_tlast;
    logic [15:0]       dis_cnt, u_dis_cnt;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          exp_dis  = 0;
    logic [31:0] last_m, last_u;

    always #5 clk = ~clk;

    ensemble_voter #(.NUM_CLS(NC), .DATA_WIDTH(DW), .KEEP_WIDTH(KW),
                     .LABEL_WIDTH(8), .VOTE_MODE(0)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast),
        .m_axis_feat_tdata(feat_tdata), .m_axis_feat_tkeep(feat_tkeep),
        .m_axis_feat_tvalid(feat_tvalid), .m_axis_feat_tready(feat_tready),
        .m_axis_feat_tlast(feat_tlast),
        .s_axis_res_tdata(res_tdata), .s_axis_res_tvalid(res_tvalid),
        .s_axis_res_tready(res_tready),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
        .disagree_cnt(dis_cnt)
    );

    ensemble_voter #(.NUM_CLS(NC), .DATA_WIDTH(DW), .KEEP_WIDTH(KW),
                     .LABEL_WIDTH(8), .VOTE_MODE(1)) dut_u (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(u_s_tready), .s_axis_tlast(s_tlast),
        .m_axis_feat_tdata(u_feat_tdata), .m_axis_feat_tkeep(u_feat_tkeep),
        .m_axis_feat_tvalid(u_feat_tvalid), .m_axis_feat_tready(feat_tready),
        .m_axis_feat_tlast(u_feat_tlast),
        .s_axis_res_tdata(res_tdata), .s_axis_res_tvalid(res_tvalid),
        .s_axis_res_tready(u_res_tready),
        .m_axis_tdata(u_m_tdata), .m_axis_tkeep(u_m_tkeep), .m_axis_tvalid(u_m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(u_m_tlast),
        .disagree_cnt(u_dis_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference vote: histogram of labels, first channel reaching the top count wins.
    function automatic logic [31:0] ref_vote(input logic [7:0] lab [3], input bit unan);
        int          hist [int];
        int          best;
        logic [7:0]  win;
        best = 0;
        win  = 8'd0;
        for (int i = 0; i < 3; i++) begin
            if (hist.exists(int'(lab[i]))) hist[int'(lab[i])] = hist[int'(lab[i])] + 1;
            else hist[int'(lab[i])] = 1;
        end
        for (int i = 0; i < 3; i++) begin
            if (hist[int'(lab[i])] > best) begin
                best = hist[int'(lab[i])];
                win  = lab[i];
            end
        end
        if (unan && hist.num() != 1) win = 8'hFF;
        return {16'h0000, 8'(best), win};
    endfunction

    // One inference through the voter; entered and left at 1 time unit after an edge.
    task automatic do_vote(input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2,
                           input int d0, input int d1, input int d2, input int stall);
        logic [7:0]  lab [3];
        int          dly [3];
        bit          pend [3];
        logic [31:0] exp_m, exp_u;
        logic [2:0]  hs;
        int          cyc, lat, max_d;
        bit          differ;
        lab    = '{l0, l1, l2};
        dly    = '{d0, d1, d2};
        exp_m  = ref_vote(lab, 1'b0);
        exp_u  = ref_vote(lab, 1'b1);
        differ = (l0 != l1) || (l1 != l2);
        max_d  = (d0 > d1) ? d0 : d1;
        max_d  = (max_d > d2) ? max_d : d2;
        pend   = '{1'b1, 1'b1, 1'b1};
        cyc    = 0;
        while ((pend[0] || pend[1] || pend[2]) && cyc < 64) begin
            for (int i = 0; i < 3; i++) begin
                res_tvalid[i]          = pend[i] && (cyc >= dly[i]);
                res_tdata[i*DW +: DW]  = {24'($urandom), lab[i]};
            end
            #1;
            check("res_tready_collect", 32'(res_tready), 32'({pend[2], pend[1], pend[0]}));
            hs = res_tvalid & res_tready;
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) if (hs[i]) pend[i] = 1'b0;
            cyc++;
        end
        res_tvalid = '0;
        check("capture_cycles", 32'(cyc), 32'(max_d + 1));
        lat = 0;
        while (!m_tvalid && lat < 16) begin
            @(posedge clk); #1;
            lat++;
        end
        check("vote_latency", 32'(lat), 32'd2);
        check("u_tvalid", 32'(u_m_tvalid), 32'd1);
        check("vote_maj", m_tdata, exp_m);
        check("vote_unan", u_m_tdata, exp_u);
        check("m_tkeep_tlast", 32'({m_tkeep, m_tlast}), 32'h1F);
        last_m = m_tdata;
        last_u = u_m_tdata;
        for (int s = 0; s < stall; s++) begin
            res_tvalid = '1;
            #1;
            check("res_tready_out", 32'({res_tready, u_res_tready}), 32'd0);
            @(posedge clk); #1;
            check("hold_valid", 32'({m_tvalid, u_m_tvalid}), 32'd3);
            check("hold_maj", m_tdata, exp_m);
            check("hold_unan", u_m_tdata, exp_u);
        end
        res_tvalid = '0;
        m_tready   = 1'b1;
        @(posedge clk); #1;
        m_tready = 1'b0;
        if (differ && exp_dis != 16'hFFFF) exp_dis++;
        check("tvalid_after_hs", 32'({m_tvalid, u_m_tvalid}), 32'd0);
        check("disagree_maj", 32'(dis_cnt), 32'(exp_dis));
        check("disagree_unan", 32'(u_dis_cnt), 32'(exp_dis));
        check("res_tready_rearm", 32'(res_tready), 32'h7);
    endtask

    // Random feature stream with random per-channel backpressure.
    task automatic bcast_random(input int nbeats);
        logic [31:0] beats [$];
        int          got [3];
        int          cur, cyc;
        logic [2:0]  exp_v;
        bit          exp_r;
        for (int k = 0; k < nbeats; k++) beats.push_back($urandom);
        got = '{0, 0, 0};
        cur = 0;
        cyc = 0;
        while (cur < nbeats && cyc < 5000) begin
            s_tvalid    = ($urandom_range(0, 3) != 0);
            s_tdata     = beats[cur];
            s_tkeep     = beats[cur][3:0];
            s_tlast     = (cur == nbeats - 1);
            feat_tready = 3'($urandom);
            #1;
            exp_r = 1'b1;
            for (int i = 0; i < 3; i++) begin
                exp_v[i] = s_tvalid && (got[i] == cur);
                if (!(got[i] > cur || feat_tready[i])) exp_r = 1'b0;
            end
            check("s_tready", 32'(s_tready), 32'(exp_r));
            check("feat_tvalid", 32'(feat_tvalid), 32'(exp_v));
            for (int i = 0; i < 3; i++) begin
                if (feat_tvalid[i] && feat_tready[i]) begin
                    check("feat_tdata", feat_tdata[i*DW +: DW],
                          (got[i] < nbeats) ? beats[got[i]] : 32'hDEAD_BEEF);
                    check("feat_tkeep_tlast", 32'({feat_tkeep[i*KW +: KW], feat_tlast[i]}),
                          32'({s_tkeep, s_tlast}));
                    got[i]++;
                end
            end
            if (s_tvalid && s_tready) cur++;
            @(posedge clk); #1;
            cyc++;
        end
        s_tvalid    = 1'b0;
        feat_tready = '1;
        check("bcast_all_beats", 32'(cur), 32'(nbeats));
        for (int i = 0; i < 3; i++) check("bcast_chan_count", 32'(got[i]), 32'(nbeats));
    endtask

    initial begin
        logic [2:0] rdy_tab [4];
        bit         srdy_tab [4];
        int         hs_cnt [3];

        rst         = 1'b1;
        s_tdata     = '0;
        s_tkeep     = '0;
        s_tvalid    = 1'b0;
        s_tlast     = 1'b0;
        feat_tready = '1;
        res_tdata   = '0;
        res_tvalid  = '0;
        m_tready    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tvalid", 32'({m_tvalid, u_m_tvalid}), 32'd0);
        check("rst_tdata", m_tdata, 32'd0);
        check("rst_disagree", 32'(dis_cnt), 32'd0);
        check("rst_res_tready", 32'(res_tready), 32'h7);
        check("rst_s_tready", 32'(s_tready), 32'd1);
        rst = 1'b0;

        // Results accepted on the very first edge after reset release.
        do_vote(8'd2, 8'd2, 8'd5, 0, 0, 0, 0);
        check("ex_225", last_m, 32'h0000_0202);
        check("ex_225_dis", 32'(dis_cnt), 32'd1);
        do_vote(8'd1, 8'd4, 8'd7, 0, 0, 0, 1);
        check("ex_tie_147", last_m, 32'h0000_0101);
        do_vote(8'd3, 8'd3, 8'd4, 2, 0, 1, 0);
        check("ex_unan_334", last_u, 32'h0000_02FF);
        do_vote(8'd6, 8'd6, 8'd6, 1, 3, 0, 5);
        check("ex_unan_666", last_u, 32'h0000_0306);
        check("ex_666_dis", 32'(u_dis_cnt), 32'd3);

        // Channel 1 stalls three cycles while 0 and 2 accept.
        rdy_tab  = '{3'b101, 3'b101, 3'b101, 3'b111};
        srdy_tab = '{1'b0, 1'b0, 1'b0, 1'b1};
        hs_cnt   = '{0, 0, 0};
        s_tvalid = 1'b1;
        s_tdata  = 32'hA5A5_0001;
        s_tkeep  = 4'hF;
        s_tlast  = 1'b1;
        for (int c = 0; c < 4; c++) begin
            feat_tready = rdy_tab[c];
            #1;
            check("stall_s_tready", 32'(s_tready), 32'(srdy_tab[c]));
            for (int i = 0; i < 3; i++) if (feat_tvalid[i] && feat_tready[i]) hs_cnt[i]++;
            @(posedge clk); #1;
        end
        s_tvalid    = 1'b0;
        feat_tready = '1;
        for (int i = 0; i < 3; i++) check("stall_hs_count", 32'(hs_cnt[i]), 32'd1);

        // Feature traffic and voting run concurrently.
        fork
            bcast_random(200);
            begin
                for (int v = 0; v < 40; v++) begin
                    do_vote(8'($urandom_range(0, 3)), 8'($urandom_range(0, 3)),
                            8'($urandom_range(0, 3)), $urandom_range(0, 3),
                            $urandom_range(0, 3), $urandom_range(0, 3),
                            $urandom_range(0, 3));
                end
            end
        join

        // Reset asserted while a vote beat is held in OUT.
        res_tvalid = '1;
        res_tdata  = {32'd9, 32'd8, 32'd7};
        #1;
        @(posedge clk); #1;
        res_tvalid = '0;
        repeat (2) @(posedge clk);
        #1;
        check("pre_rst_tvalid", 32'(m_tvalid), 32'd1);
        rst = 1'b1;
        #1;
        check("midout_rst_tvalid", 32'({m_tvalid, u_m_tvalid}), 32'd0);
        check("midout_rst_dis", 32'({dis_cnt, u_dis_cnt}), 32'd0);
        check("midout_rst_tdata", m_tdata, 32'd0);
        check("midout_rst_res_rdy", 32'(res_tready), 32'h7);
        @(posedge clk); #1;
        rst     = 1'b0;
        exp_dis = 0;
        do_vote(8'd5, 8'd1, 8'd5, 0, 1, 2, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ensemble_voter.md
ENSEMBLE_VOTER -- requirements
Module: ensemble_voter
Interface
REQ-001 SHALL have parameter NUM_CLS, default 3, number of classifier channels (legal 1..7).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, AXI-Stream data width (SHALL be >= LABEL_WIDTH+8).
REQ-003 SHALL have parameter KEEP_WIDTH, default 4, AXI-Stream keep width (DATA_WIDTH/8).
REQ-004 SHALL have parameter LABEL_WIDTH, default 8, class label width in bits [LABEL_WIDTH-1:0] of each result beat.
REQ-005 SHALL have parameter VOTE_MODE, default 0; 0 = majority vote, 1 = unanimous.
REQ-006 The block SHALL use one clock and an asynchronous, active-high reset, with ports as listed below.
REQ-007 clk  in  1  single clock; all state on rising edge.
REQ-008 rst  in  1  asynchronous, active-high reset.
REQ-009 s_axis_tdata  in  DATA_WIDTH  feature beat to broadcast.
REQ-010 s_axis_tkeep  in  KEEP_WIDTH  feature keep.
REQ-011 s_axis_tvalid  in  1  feature valid.
REQ-012 s_axis_tready  out  1  feature ready.
REQ-013 s_axis_tlast  in  1  last feature of inference.
REQ-014 m_axis_feat_tdata  out  NUM_CLS*DATA_WIDTH  per-classifier copy of s_axis_tdata; channel i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-015 m_axis_feat_tkeep  out  NUM_CLS*KEEP_WIDTH  per-classifier copy of s_axis_tkeep.
REQ-016 m_axis_feat_tvalid  out  NUM_CLS  per-classifier valid.
REQ-017 m_axis_feat_tready  in  NUM_CLS  per-classifier ready.
REQ-018 m_axis_feat_tlast  out  NUM_CLS  per-classifier copy of s_axis_tlast.
REQ-019 s_axis_res_tdata  in  NUM_CLS*DATA_WIDTH  classifier result beats, label in low LABEL_WIDTH bits of each slice.
REQ-020 s_axis_res_tvalid  in  NUM_CLS  result valid per classifier.
REQ-021 s_axis_res_tready  out  NUM_CLS  result ready per classifier.
REQ-022 m_axis_tdata  out  DATA_WIDTH  vote: [LABEL_WIDTH-1:0] label, [LABEL_WIDTH+7:LABEL_WIDTH] winner vote count, upper bits 0.
REQ-023 m_axis_tkeep  out  KEEP_WIDTH  all ones.
REQ-024 m_axis_tvalid  out  1  vote valid.
REQ-025 m_axis_tready  in  1  vote ready.
REQ-026 m_axis_tlast  out  1  constant 1 (one beat per inference).
REQ-027 disagree_cnt  out  16  saturating count of emitted votes whose NUM_CLS labels were not all equal.
Function
REQ-028 Broadcast: m_axis_feat_tvalid[i] = s_axis_tvalid & ~done[i]; s_axis_tready = AND over i of (done[i] | m_axis_feat_tready[i]); combinational, zero latency.
REQ-029 done[i] SHALL set on channel-i handshake without input handshake, and clear on every s_axis handshake; each channel receives each feature beat exactly once, in order.
REQ-030 Voter FSM states COLLECT, VOTE, OUT; COLLECT -> VOTE on the edge where all captured[i] are 1; VOTE -> OUT unconditionally; OUT -> COLLECT on m_axis handshake.
REQ-031 In COLLECT, s_axis_res_tready[i] = ~captured[i]; on handshake the label is registered and captured[i] set; simultaneous captures on several channels in one cycle SHALL all be accepted.
REQ-032 In VOTE and OUT, all s_axis_res_tready SHALL be 0; extra result beats stall upstream.
REQ-033 In VOTE: count, per channel, the number of channels with equal label; winner = label with maximum count; ties resolve to the lowest channel index among tied labels; result registered.
REQ-034 VOTE_MODE=1: if not all labels equal, label field SHALL be all ones; count field still holds maximum count.
REQ-035 m_axis_tvalid SHALL rise exactly 2 cycles after the final result capture edge and hold stable with data until m_axis_tready.
REQ-036 On OUT handshake, captured[] SHALL clear and disagree_cnt increment by 1 if labels differed, saturating at 0xFFFF.
REQ-037 Broadcast path and voter path SHALL operate independently; feature beats of the next inference may flow while the voter is in VOTE or OUT.
Reset
REQ-038 While rst=1: m_axis_tvalid=0, all done[]=0, captured[]=0, FSM=COLLECT, m_axis_tdata=0, disagree_cnt=0; effective immediately, including mid-broadcast or mid-OUT.
REQ-039 First transfer SHALL be accepted on the first rising edge after rst deasserts.
Structure
REQ-040 Shared package ensemble_pkg SHALL hold the voter state enumeration, VOTE_MAJORITY/VOTE_UNANIMOUS constants and the count-field width constant (8).
REQ-041 The broadcast fork SHALL be a sub-module axis_broadcast (NUM_CLS, DATA_WIDTH, KEEP_WIDTH); voting logic stays in ensemble_voter.
Verification
REQ-042 NUM_CLS=3, majority, labels 2,2,5 -> m_axis_tdata=0x00000202, disagree_cnt=1 after handshake.
REQ-043 Labels 1,4,7 arriving on one cycle -> tie, m_axis_tdata=0x00000101, tvalid 2 cycles after capture.
REQ-044 VOTE_MODE=1, labels 3,3,4 -> m_axis_tdata=0x000002FF; labels 6,6,6 -> 0x00000306, disagree_cnt unchanged.
REQ-045 m_axis_feat_tready[1]=0 for 3 cycles, others 1 -> channels 0,2 each see one handshake, s_axis_tready=0 until channel 1 accepts, no duplicate beats.
REQ-046 m_axis_tready=0 for 5 cycles in OUT -> tdata stable, res_tready=0; rst pulse mid-OUT -> tvalid=0, disagree_cnt=0 immediately.
